poly_tone_gen: RTL
==================

Name: poly_tone_gen

Overview:
Parametrised multi-voice square-wave tone generator. It generalises the single fixed-table note oscillator to N independently programmable voices. Each voice has a runtime-writable half-period, glitch-free period updates, per-voice enable, and a mute code. It sits between the sequencer/control logic and the audio output stage, and also provides a registered voice-count mix for a downstream DAC/PWM.

Parameters:
N_VOICES, 4, number of independent voices (>=1)
CNT_W, 16, width of half-period registers and counters
DEFAULT_HALF_PERIOD, 13514, reset value of every voice's active and shadow half-period (CNT_W bits)
Derived (localparam): AW = max(1, clog2(N_VOICES)); MIX_W = clog2(N_VOICES+1)

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous reset, active-high
WR_EN  input  1  write strobe for a half-period shadow register
WR_ADDR  input  AW  voice index for write
WR_DATA  input  CNT_W  new half-period in CLK cycles; 0 = mute
VOICE_EN  input  N_VOICES  per-voice enable
AUDIO  output  N_VOICES  per-voice square-wave output (registered)
PENDING  output  N_VOICES  shadow value written but not yet applied
MIX  output  MIX_W  registered count of AUDIO bits high

Behaviour:
- Async RST high: AUDIO=0, MIX=0, PENDING=0, all counters=0, ACTIVE[i]=SHADOW[i]=DEFAULT_HALF_PERIOD. All outputs are registered; nothing changes while RST is held.
- Write: on a CLK edge with WR_EN=1 and WR_ADDR<N_VOICES, SHADOW[WR_ADDR]<=WR_DATA and PENDING[WR_ADDR]<=1. If WR_ADDR>=N_VOICES, the write is ignored with no state change.
- Per voice i, evaluated in priority order each edge:
  1. VOICE_EN[i]=0: AUDIO[i]<=0, CNT[i]<=0. If PENDING[i], ACTIVE[i]<=SHADOW[i] and PENDING[i]<=0.
  2. ACTIVE[i]==0 (muted): AUDIO[i]<=0, CNT[i]<=0. If PENDING[i], load immediately as in case 1.
  3. CNT[i]>=ACTIVE[i]-1 (terminal count): CNT[i]<=0 and AUDIO[i] toggles. If PENDING[i], ACTIVE[i]<=SHADOW[i] and PENDING[i]<=0. If the loaded value is 0, AUDIO[i]<=0 instead of toggling.
  4. Otherwise: CNT[i]<=CNT[i]+1.
- Timing: each AUDIO level lasts exactly ACTIVE cycles, so the full period is 2*ACTIVE cycles. After reset release or enable, the first rise occurs on the ACTIVE-th edge.
- Glitch-free rule: while a voice is enabled and unmuted, a new period takes effect only at a toggle boundary. No half-cycle is ever shorter than min(old, new) half-period.
- Simultaneous write and terminal count with PENDING on the same voice: ACTIVE takes the pre-write SHADOW value. The new write is stored and PENDING stays 1, so it is applied at the next boundary.
- Repeated writes before a boundary: the last write wins.
- ACTIVE=1 gives a toggle every cycle (period 2). CNT_W-bit arithmetic; CNT never exceeds ACTIVE-1 in normal operation, and the >= compare covers the case where it does.
- MIX <= popcount(AUDIO) sampled each edge. MIX lags AUDIO by one cycle.
- Reset mid-operation: all state returns immediately to reset values. Pending writes are discarded.

Test Plan:
- N_VOICES=4, DEFAULT_HALF_PERIOD=4, all VOICE_EN=1, release RST -> all AUDIO rise on the 4th edge and toggle every 4 cycles; MIX=4 one cycle after the rise, MIX=0 one cycle after the fall.
- Write 6 to voice 1 at 2 cycles into a high phase -> PENDING[1]=1; the high phase still lasts 4 cycles; subsequent phases last 6 cycles; PENDING[1] clears at that boundary.
- Write 0 to voice 2 -> AUDIO[2] stays at its current level until the boundary, then is 0 permanently. A later write of 5 is applied on the next edge, and the first rise follows 5 cycles later.
- Write 8 to voice 0 on the same edge as its terminal count, with 3 already pending -> the next phase is 3 cycles with PENDING[0]=1, the following phases are 8 cycles, and PENDING[0]=0.
- Drop VOICE_EN[3] mid-high with 7 pending -> AUDIO[3]=0 next edge and ACTIVE=7 applied. Re-enable -> first rise 7 cycles later.
- WR_ADDR=5 with N_VOICES=4 -> no change in PENDING or periods. Assert RST mid-phase -> AUDIO, MIX and PENDING all 0 asynchronously, and defaults are restored.

Source files
------------

// File: rtl/poly_tone_gen.sv
// -----------------------------------------------------------------------------
// poly_tone_gen
//   N independent square-wave voices. Each voice counts CLK cycles up to its
//   active half-period and toggles its output, so one output level lasts
//   ACTIVE cycles and the full period is 2*ACTIVE. A new half-period is written
//   into a per-voice shadow register. While the voice runs, that value only
//   reaches the active register at a toggle boundary, so no phase is ever cut
//   short. A half-period of 0 mutes the voice.
//
// Ports
//   CLK       system clock
//   RST       asynchronous reset, active-high
//   WR_EN     shadow write strobe
//   WR_ADDR   voice index of the write (out-of-range indices are ignored)
//   WR_DATA   new half-period in CLK cycles, 0 = mute
//   VOICE_EN  per-voice enable
//   AUDIO     per-voice square wave (registered)
//   PENDING   per-voice "shadow written, not yet applied"
//   MIX       registered count of AUDIO bits high, one cycle behind AUDIO
// -----------------------------------------------------------------------------
module poly_tone_gen #(
    parameter int               N_VOICES            = 4,
    parameter int               CNT_W               = 16,
    parameter logic [CNT_W-1:0] DEFAULT_HALF_PERIOD = CNT_W'(13514),
    localparam int              AW                  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1,
    localparam int              MIX_W               = $clog2(N_VOICES + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WR_EN,
    input  logic [AW-1:0]       WR_ADDR,
    input  logic [CNT_W-1:0]    WR_DATA,
    input  logic [N_VOICES-1:0] VOICE_EN,
    output logic [N_VOICES-1:0] AUDIO,
    output logic [N_VOICES-1:0] PENDING,
    output logic [MIX_W-1:0]    MIX
);

    logic [CNT_W-1:0]    cnt_q    [N_VOICES];
    logic [CNT_W-1:0]    cnt_d    [N_VOICES];
    logic [CNT_W-1:0]    active_q [N_VOICES];
    logic [CNT_W-1:0]    active_d [N_VOICES];
    logic [CNT_W-1:0]    shadow_q [N_VOICES];
    logic [CNT_W-1:0]    shadow_d [N_VOICES];
    logic [N_VOICES-1:0] audio_q, audio_d;
    logic [N_VOICES-1:0] pending_q, pending_d;
    logic [MIX_W-1:0]    mix_q, mix_d;

    always_comb begin
        // NOTE: every signal starts from its held value, so no branch below can leave one unassigned and infer a latch.
        audio_d   = audio_q;
        pending_d = pending_q;
        mix_d     = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            cnt_d[i]    = cnt_q[i];
            active_d[i] = active_q[i];
            shadow_d[i] = shadow_q[i];

            if (!VOICE_EN[i] || active_q[i] == '0) begin
                // Disabled or muted: hold low, and a pending value can load at
                // once because there is no running phase to protect.
                audio_d[i] = 1'b0;
                cnt_d[i]   = '0;
                if (pending_q[i]) begin
                    active_d[i]  = shadow_q[i];
                    pending_d[i] = 1'b0;
                end
            end else if (cnt_q[i] >= active_q[i] - CNT_W'(1)) begin
                // Terminal count: the only point where a running voice may
                // change period. Loading 0 here silences it instead of toggling.
                cnt_d[i] = '0;
                if (pending_q[i]) begin
                    active_d[i]  = shadow_q[i];
                    pending_d[i] = 1'b0;
                    audio_d[i]   = (shadow_q[i] != '0) && !audio_q[i];
                end else begin
                    audio_d[i] = !audio_q[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // The write is applied after the load above. A load on this edge
            // therefore takes the pre-write shadow, and the new value stays pending.
            if (WR_EN && int'(WR_ADDR) == i) begin
                shadow_d[i]  = WR_DATA;
                pending_d[i] = 1'b1;
            end

            mix_d = mix_d + MIX_W'(audio_q[i]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            audio_q   <= '0;
            pending_q <= '0;
            mix_q     <= '0;
            // NOTE: these per-voice arrays are small flop banks, not RAM, so they take the async reset like any other state.
            for (int i = 0; i < N_VOICES; i++) begin
                cnt_q[i]    <= '0;
                active_q[i] <= DEFAULT_HALF_PERIOD;
                shadow_q[i] <= DEFAULT_HALF_PERIOD;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
            audio_q   <= audio_d;
            pending_q <= pending_d;
            mix_q     <= mix_d;
            for (int i = 0; i < N_VOICES; i++) begin
                cnt_q[i]    <= cnt_d[i];
                active_q[i] <= active_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign AUDIO   = audio_q;
    assign PENDING = pending_q;
    assign MIX     = mix_q;

endmodule
